// File: rtl/ov7670_sim_tx_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_sim_tx_pkg
// Shared definitions for the OV7670 camera-stream simulator:
//   - tx_state_t   : frame-timing FSM states
//   - DEF_*        : default frame geometry / blanking lengths (pclk cycles)
//   - rgb565_byte  : picks the high or low byte of an RGB565 pixel word
// ---------------------------------------------------------------------------
package ov7670_sim_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    HBLANK = 3'd4,
    VFRONT = 3'd5
  } tx_state_t;

  localparam int DEF_COLS   = 160;
  localparam int DEF_ROWS   = 120;
  localparam int DEF_VS_CYC = 16;
  localparam int DEF_VBP    = 8;
  localparam int DEF_HBLK   = 12;
  localparam int DEF_VFP    = 8;

  // The sensor sends each pixel as two bytes: word[15:8] first, then word[7:0].
  // For RGB565 this gives {R[4:0],G[5:3]} followed by {G[2:0],B[4:0]}.
  function automatic logic [7:0] rgb565_byte(input logic [15:0] word,
                                             input logic        low_sel);
    return low_sel ? word[7:0] : word[15:8];
  endfunction

endpackage

// File: rtl/ov7670_sim_tx_pattern.sv
// ---------------------------------------------------------------------------
// ov7670_pattern
// Purely combinational test-pattern source producing one RGB565 word for the
// pixel at (row, col).
//   row     in  ROW_W  line index of the pixel
//   col     in  COL_W  pixel index within the line
//   pat_sel in  1      0 = eight vertical color bars, 1 = coordinate pattern
//   rgb     out 16     RGB565 pixel word
// ---------------------------------------------------------------------------
module ov7670_pattern
  import ov7670_sim_tx_pkg::*;
#(
  parameter int COLS  = DEF_COLS,
  parameter int ROW_W = 7,
  parameter int COL_W = 8
) (
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  input  logic             pat_sel,
  output logic [15:0]      rgb
);

  logic [COL_W+3:0] col_x8;
  logic [2:0]       bar;
  logic [4:0]       r;
  logic [5:0]       g;
  logic [4:0]       b;

  always_comb begin
    // bar = col*8/COLS; one spare bit keeps col*8 from overflowing.
    col_x8 = {1'b0, col, 3'b000};
    bar    = 3'(col_x8 / (COL_W+4)'(COLS));
    r      = bar[2] ? 5'h1f  : 5'h00;
    g      = bar[1] ? 6'h3f  : 6'h00;
    b      = bar[0] ? 5'h1f  : 5'h00;
    if (pat_sel) begin
      rgb = {8'(row), 8'(col)};
    end else begin
      rgb = {r, g, b};
    end
  end

endmodule

// File: rtl/ov7670_sim_tx.sv
// ---------------------------------------------------------------------------
// ov7670_sim_tx
// Generates an OV7670-style parallel video stream (vsync / href / 8-bit data)
// from an internal test pattern, one byte per pclk.
//   pclk       in  1  clock; every output is registered on its rising edge
//   rst        in  1  synchronous active-high reset
//   en         in  1  start frames while high (checked at frame boundaries)
//   pat_sel    in  1  0 = color bars, 1 = coordinate pattern (latched per frame)
//   vsync      out 1  high for VS_CYC cycles at the start of each frame
//   href       out 1  high while px_data carries pixel bytes
//   px_data    out 8  pixel bytes, high byte then low byte; 0 while href=0
//   frame_done out 1  one-cycle pulse in the last cycle of a frame
//   frame_cnt  out 8  number of completed frames, wraps at 256
//
// Stream semantics: href acts as the byte-valid strobe. There is no ready;
// the receiver must accept a byte on every pclk where href=1.
//
// Frame layout: VSYNC(VS_CYC) VBACK(VBP) { ACTIVE(2*COLS) HBLANK(HBLK) }
// repeated ROWS times without the final HBLANK, then VFRONT(VFP).
// The FSM state is kept in the signal `state` for external checkers.
// ---------------------------------------------------------------------------
module ov7670_sim_tx
  import ov7670_sim_tx_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int VS_CYC = DEF_VS_CYC,
  parameter int VBP    = DEF_VBP,
  parameter int HBLK   = DEF_HBLK,
  parameter int VFP    = DEF_VFP
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       en,
  input  logic       pat_sel,
  output logic       vsync,
  output logic       href,
  output logic [7:0] px_data,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);

  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int MAX_A   = (VS_CYC > VBP) ? VS_CYC : VBP;
  localparam int MAX_B   = (HBLK > VFP) ? HBLK : VFP;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(VS_CYC - 1);
  localparam logic [CNT_W-1:0] VBP_LAST  = CNT_W'(VBP - 1);
  localparam logic [CNT_W-1:0] HBLK_LAST = CNT_W'(HBLK - 1);
  localparam logic [CNT_W-1:0] VFP_LAST  = CNT_W'(VFP - 1);
  localparam logic [CNT_W-1:0] VFP_PRE   = CNT_W'(VFP - 2);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;      // cycles spent in the current blanking state
  logic [ROW_W-1:0] row;      // line of the byte on px_data (or the next line)
  logic [COL_W-1:0] col;      // pixel of the byte on px_data
  logic             byte_lo;  // 1 when px_data holds the low byte
  logic             pat_q;    // pattern select frozen for the current frame
  logic [COL_W-1:0] pat_col;
  logic [15:0]      pix_word;

  // px_data is registered, so the pattern is looked up for the byte that will
  // be presented after the next edge. Only the step from a low byte to the
  // next pixel's high byte needs a different column than the current one.
  always_comb begin
    pat_col = col;
    if (state == ACTIVE && byte_lo && col != COL_LAST) begin
      pat_col = col + COL_W'(1);
    end
  end

  ov7670_pattern #(
    .COLS  (COLS),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_pattern (
    .row     (row),
    .col     (pat_col),
    .pat_sel (pat_q),
    .rgb     (pix_word)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      row        <= '0;
      col        <= '0;
      byte_lo    <= 1'b0;
      pat_q      <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      px_data    <= 8'h00;
      frame_done <= 1'b0;
      frame_cnt  <= 8'h00;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state <= VSYNC;
            vsync <= 1'b1;
            cnt   <= '0;
            row   <= '0;
            col   <= '0;
            pat_q <= pat_sel;
          end
        end

        VSYNC: begin
          if (cnt == VS_LAST) begin
            state <= VBACK;
            vsync <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        VBACK: begin
          if (cnt == VBP_LAST) begin
            state   <= ACTIVE;
            href    <= 1'b1;
            byte_lo <= 1'b0;
            px_data <= rgb565_byte(pix_word, 1'b0);
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ACTIVE: begin
          if (!byte_lo) begin
            byte_lo <= 1'b1;
            px_data <= rgb565_byte(pix_word, 1'b1);
          end else if (col != COL_LAST) begin
            byte_lo <= 1'b0;
            col     <= col + COL_W'(1);
            px_data <= rgb565_byte(pix_word, 1'b0);
          end else begin
            // Last byte of the line has just been shown.
            href    <= 1'b0;
            px_data <= 8'h00;
            byte_lo <= 1'b0;
            cnt     <= '0;
            if (row != ROW_LAST) begin
              state <= HBLANK;
              row   <= row + ROW_W'(1);
              col   <= '0;
            end else begin
              state <= VFRONT;
              if (VFP == 1) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 8'd1;
              end
            end
          end
        end

        HBLANK: begin
          if (cnt == HBLK_LAST) begin
            state   <= ACTIVE;
            href    <= 1'b1;
            byte_lo <= 1'b0;
            px_data <= rgb565_byte(pix_word, 1'b0);
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        VFRONT: begin
          if (cnt == VFP_LAST) begin
            cnt <= '0;
            // Chain straight into the next frame when still enabled.
            if (en) begin
              state <= VSYNC;
              vsync <= 1'b1;
              row   <= '0;
              col   <= '0;
              pat_q <= pat_sel;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            // Raise frame_done so it is visible during the final VFRONT cycle.
            if (VFP > 1 && cnt == VFP_PRE) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 8'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
